uart_word_assembler: RTL and testbench



---
 rtl/uart_word_assembler_pkg.sv | 15 +
 rtl/uart_word_fifo.sv | 52 +++++
 rtl/uart_word_assembler.sv | 92 +++++++++
 tb/tb_uart_word_assembler.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/uart_word_assembler_pkg.sv
// Shared defaults for the UART word assembler and its uart_rx neighbours.
package uart_word_assembler_pkg;

  localparam int DEF_BYTE_BITS    = 8;
  localparam int DEF_WORD_BYTES   = 4;
  localparam int DEF_WORD_BITS    = DEF_WORD_BYTES * DEF_BYTE_BITS;
  localparam int DEF_TIMEOUT_CLKS = 20000;
  localparam int DEF_FIFO_DEPTH   = 4;

  // Width of a counter that must hold values 0..n-1 (at least 1 bit).
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// Generic synchronous FIFO. A push into a full FIFO succeeds only when a pop
// happens in the same cycle; otherwise the push is ignored.
module uart_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage, pointers and level; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_word_assembler.sv
// Packs consecutive UART bytes (first byte in the LSBs) into words, buffers
// them in a small FIFO and drops stale partial words after an idle timeout.
module uart_word_assembler
  import uart_word_assembler_pkg::*;
#(
  parameter int BYTE_BITS    = DEF_BYTE_BITS,
  parameter int WORD_BYTES   = DEF_WORD_BYTES,
  parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [BYTE_BITS-1:0]              in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WORD_BYTES*BYTE_BITS-1:0]   out_data,
  output logic [$clog2(FIFO_DEPTH):0]       fill_level,
  output logic                              overflow,
  output logic                              partial_drop
);

  localparam int IW = cnt_w(WORD_BYTES);
  localparam int TW = cnt_w(TIMEOUT_CLKS);

  logic [WORD_BYTES-1:0][BYTE_BITS-1:0] asm_q;
  logic [WORD_BYTES-1:0][BYTE_BITS-1:0] word;
  logic [IW-1:0]                        idx;
  logic [TW-1:0]                        tcnt;
  logic                                 complete, timeout, pop, full, empty;

  assign complete  = in_valid && (idx == IW'(WORD_BYTES-1));
  // A byte in the same cycle always wins over the timeout.
  assign timeout   = !in_valid && (idx != '0) && (tcnt == TW'(TIMEOUT_CLKS-1));
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  // Word as it will look with the current byte merged into its slot; this is
  // what gets pushed when the last byte arrives.
  for (genvar b = 0; b < WORD_BYTES; b++) begin : g_slot
    assign word[b] = (in_valid && idx == IW'(b)) ? in_data : asm_q[b];
  end

  // Byte collector: slot write and index advance / wrap / timeout clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      asm_q <= '0;
      idx   <= '0;
    end else if (in_valid) begin
      asm_q <= word;
      idx   <= complete ? '0 : idx + 1'b1;
    end else if (timeout) begin
      idx <= '0;
    end
  end

  // Inter-byte timeout counter; idle at 0 while no partial word is pending.
  always_ff @(posedge clk) begin
    if (reset || in_valid || timeout || idx == '0)
      tcnt <= '0;
    else
      tcnt <= tcnt + 1'b1;
  end

  // Status: sticky overflow on a dropped word, one-cycle partial drop pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow     <= 1'b0;
      partial_drop <= 1'b0;
    end else begin
      partial_drop <= timeout;
      if (complete && full && !pop)
        overflow <= 1'b1;
    end
  end

  uart_word_fifo #(
    .WIDTH (WORD_BYTES*BYTE_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (complete),
    .push_data (word),
    .pop       (pop),
    .head      (out_data),
    .level     (fill_level),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_uart_word_assembler.sv
// Directed bench for uart_word_assembler: packing, timeout, overflow, reset.
module tb_uart_word_assembler;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  fill_level;
  logic        overflow;
  logic        partial_drop;

  int total = 0;
  int bad   = 0;

  uart_word_assembler #(
    .BYTE_BITS    (8),
    .WORD_BYTES   (4),
    .TIMEOUT_CLKS (TO),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .fill_level   (fill_level),
    .overflow     (overflow),
    .partial_drop (partial_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] exp);
    chk(tag, out_data, exp);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  initial begin
    int drops;
    int drop_at;

    // Reset state
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_fill", 32'(fill_level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_pdrop", 32'(partial_drop), 32'd0);
    chk("rst_data", out_data, 32'd0);

    // Basic packing, consumer always ready
    out_ready = 1'b1;
    send(8'h11); send(8'h22); send(8'h33);
    chk("pk_novalid", 32'(out_valid), 32'd0);
    send(8'h44);
    chk("pk_valid", 32'(out_valid), 32'd1);
    chk("pk_data", out_data, 32'h44332211);
    chk("pk_fill1", 32'(fill_level), 32'd1);
    cyc();
    chk("pk_fill0", 32'(fill_level), 32'd0);

    // Timeout drops the AA/BB partial word exactly once
    send(8'hAA); send(8'hBB);
    drops = 0; drop_at = -1;
    for (int i = 1; i <= 24; i++) begin
      cyc();
      if (partial_drop) begin
        drops++;
        drop_at = i;
      end
    end
    chk("to_count", 32'(drops), 32'd1);
    chk("to_cycle", 32'(drop_at), 32'(TO));
    send_word(32'h04030201);
    chk("to_valid", 32'(out_valid), 32'd1);
    chk("to_data", out_data, 32'h04030201);
    cyc();

    // Second byte lands exactly when the counter is at TO-1: no drop
    drops = 0;
    send(8'h55);
    for (int i = 1; i < TO; i++) begin
      cyc();
      if (partial_drop) drops++;
    end
    send(8'h66);
    if (partial_drop) drops++;
    send(8'h77);
    if (partial_drop) drops++;
    send(8'h88);
    if (partial_drop) drops++;
    chk("tb_nodrop", 32'(drops), 32'd0);
    chk("tb_data", out_data, 32'h88776655);
    cyc();
    out_ready = 1'b0;

    // Overflow: five words into a depth-4 FIFO with no consumer
    for (int k = 0; k < 5; k++) send_word({4{8'(k)}});
    chk("ov_fill", 32'(fill_level), 32'd4);
    chk("ov_flag", 32'(overflow), 32'd1);
    for (int k = 0; k < 4; k++) pop_chk($sformatf("ov_word%0d", k), {4{8'(k)}});
    chk("ov_empty", 32'(out_valid), 32'd0);
    chk("ov_sticky", 32'(overflow), 32'd1);

    // Full FIFO, last byte of a new word coincides with a pop
    do_reset();
    chk("rst2_ovf", 32'(overflow), 32'd0);
    for (int k = 1; k <= 4; k++) send_word({4{8'hA0 + 8'(k)}});
    chk("fp_full", 32'(fill_level), 32'd4);
    send(8'hE5); send(8'hE5); send(8'hE5);
    out_ready = 1'b1;
    send(8'hE5);
    out_ready = 1'b0;
    chk("fp_fill", 32'(fill_level), 32'd4);
    chk("fp_ovf", 32'(overflow), 32'd0);
    pop_chk("fp_w0", 32'hA2A2A2A2);
    pop_chk("fp_w1", 32'hA3A3A3A3);
    pop_chk("fp_w2", 32'hA4A4A4A4);
    pop_chk("fp_w3", 32'hE5E5E5E5);
    chk("fp_empty", 32'(fill_level), 32'd0);

    // Reset with two queued words and two pending bytes
    send_word(32'h13121110);
    send_word(32'h17161514);
    send(8'hF0); send(8'hF1);
    chk("mr_pre", 32'(fill_level), 32'd2);
    do_reset();
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_fill", 32'(fill_level), 32'd0);
    chk("mr_data", out_data, 32'd0);
    send_word(32'hC4C3C2C1);
    chk("mr_fill1", 32'(fill_level), 32'd1);
    chk("mr_word", out_data, 32'hC4C3C2C1);
    cyc(); cyc();
    chk("mr_one", 32'(fill_level), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
